// File: rtl/tl_source_shrinker.sv
`default_nettype none
// ============================================================================
// Module      : tl_source_shrinker
// Description : Remaps 10-bit TileLink A-channel source IDs onto a small pool
//               of SLOTS downstream IDs and restores the original ID on the
//               matching D response. Requests are admitted only while a slot
//               is free, which caps the number of outstanding transactions.
// Revision    : 1.0 - initial release
// ============================================================================
module tl_source_shrinker #(
    parameter int SLOT_BITS = 2
) (
    input  wire logic                 clock,
    input  wire logic                 reset,
    // upstream A
    output logic                      auto_in_a_ready,
    input  wire logic                 auto_in_a_valid,
    input  wire logic [2:0]           auto_in_a_bits_opcode,
    input  wire logic [2:0]           auto_in_a_bits_param,
    input  wire logic [1:0]           auto_in_a_bits_size,
    input  wire logic [9:0]           auto_in_a_bits_source,
    input  wire logic [32:0]          auto_in_a_bits_address,
    input  wire logic [7:0]           auto_in_a_bits_mask,
    input  wire logic [63:0]          auto_in_a_bits_data,
    input  wire logic                 auto_in_a_bits_corrupt,
    // upstream D
    input  wire logic                 auto_in_d_ready,
    output logic                      auto_in_d_valid,
    output logic [2:0]                auto_in_d_bits_opcode,
    output logic [1:0]                auto_in_d_bits_param,
    output logic [1:0]                auto_in_d_bits_size,
    output logic [9:0]                auto_in_d_bits_source,
    output logic                      auto_in_d_bits_sink,
    output logic                      auto_in_d_bits_denied,
    output logic [63:0]               auto_in_d_bits_data,
    output logic                      auto_in_d_bits_corrupt,
    // downstream A
    input  wire logic                 auto_out_a_ready,
    output logic                      auto_out_a_valid,
    output logic [2:0]                auto_out_a_bits_opcode,
    output logic [2:0]                auto_out_a_bits_param,
    output logic [1:0]                auto_out_a_bits_size,
    output logic [SLOT_BITS-1:0]      auto_out_a_bits_source,
    output logic [32:0]               auto_out_a_bits_address,
    output logic [7:0]                auto_out_a_bits_mask,
    output logic [63:0]               auto_out_a_bits_data,
    output logic                      auto_out_a_bits_corrupt,
    // downstream D
    output logic                      auto_out_d_ready,
    input  wire logic                 auto_out_d_valid,
    input  wire logic [2:0]           auto_out_d_bits_opcode,
    input  wire logic [1:0]           auto_out_d_bits_size,
    input  wire logic [SLOT_BITS-1:0] auto_out_d_bits_source,
    input  wire logic [63:0]          auto_out_d_bits_data,
    // status
    output logic [SLOT_BITS:0]        inflight,
    output logic                      protocol_error
);

    localparam int SLOTS = 1 << SLOT_BITS;

    logic [SLOTS-1:0]     busy_q, busy_d;
    logic [9:0]           src_q [SLOTS];
    logic [9:0]           src_d [SLOTS];
    logic [SLOT_BITS:0]   inflight_q, inflight_d;
    logic                 perr_q, perr_d;

    logic [SLOT_BITS-1:0] w_alloc_idx;
    logic                 w_alloc_found;
    logic                 w_can_alloc;
    logic                 w_a_fire;
    logic                 w_d_fire;
    logic                 w_d_hit_busy;

    // Pick the lowest-index slot that was free at the start of the cycle.
    always_comb begin
        w_alloc_idx   = '0;
        w_alloc_found = 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
            if (!busy_q[i] && !w_alloc_found) begin
                w_alloc_idx   = SLOT_BITS'(i);
                w_alloc_found = 1'b1;
            end
        end
    end

    assign w_can_alloc  = ~&busy_q;
    assign w_a_fire     = auto_in_a_valid & auto_in_a_ready;
    assign w_d_fire     = auto_out_d_valid & auto_out_d_ready;
    assign w_d_hit_busy = busy_q[auto_out_d_bits_source];

    // A channel: gate the handshake on slot availability, swap in the slot ID.
    assign auto_out_a_valid        = auto_in_a_valid & w_can_alloc;
    assign auto_in_a_ready         = auto_out_a_ready & w_can_alloc;
    assign auto_out_a_bits_source  = w_alloc_idx;
    assign auto_out_a_bits_opcode  = auto_in_a_bits_opcode;
    assign auto_out_a_bits_param   = auto_in_a_bits_param;
    assign auto_out_a_bits_size    = auto_in_a_bits_size;
    assign auto_out_a_bits_address = auto_in_a_bits_address;
    assign auto_out_a_bits_mask    = auto_in_a_bits_mask;
    assign auto_out_a_bits_data    = auto_in_a_bits_data;
    assign auto_out_a_bits_corrupt = auto_in_a_bits_corrupt;

    // D channel: pure pass-through with the original source ID restored.
    // An unoccupied slot still forwards whatever stale ID the table holds.
    assign auto_in_d_valid        = auto_out_d_valid;
    assign auto_out_d_ready       = auto_in_d_ready;
    assign auto_in_d_bits_opcode  = auto_out_d_bits_opcode;
    assign auto_in_d_bits_size    = auto_out_d_bits_size;
    assign auto_in_d_bits_data    = auto_out_d_bits_data;
    assign auto_in_d_bits_source  = src_q[auto_out_d_bits_source];
    assign auto_in_d_bits_param   = 2'b00;
    assign auto_in_d_bits_sink    = 1'b0;
    assign auto_in_d_bits_denied  = 1'b0;
    assign auto_in_d_bits_corrupt = 1'b0;

    assign inflight       = inflight_q;
    assign protocol_error = perr_q;

    // Next-state for slot table, occupancy counter and sticky error flag.
    always_comb begin
        busy_d     = busy_q;
        src_d      = src_q;
        inflight_d = inflight_q;
        perr_d     = perr_q;

        // Free first, allocate second: the allocated slot was free at the
        // start of the cycle, so it can only coincide with the freed slot on
        // a stray response, in which case the new allocation must win.
        if (w_d_fire) begin
            busy_d[auto_out_d_bits_source] = 1'b0;
            if (!w_d_hit_busy) begin
                perr_d = 1'b1;
            end
        end
        if (w_a_fire) begin
            busy_d[w_alloc_idx] = 1'b1;
            src_d[w_alloc_idx]  = auto_in_a_bits_source;
        end

        // Only a response to an occupied slot releases a slot, which keeps
        // the counter equal to table occupancy and stops it from wrapping.
        case ({w_a_fire, w_d_fire && w_d_hit_busy})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase
    end

    // State registers; reset clears the table immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q     <= '0;
            inflight_q <= '0;
            perr_q     <= 1'b0;
            for (int i = 0; i < SLOTS; i++) begin
                src_q[i] <= '0;
            end
        end else begin
            busy_q     <= busy_d;
            src_q      <= src_d;
            inflight_q <= inflight_d;
            perr_q     <= perr_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tl_source_shrinker.sv
`default_nettype none
// ============================================================================
// Module      : tb_tl_source_shrinker
// Description : Directed self-checking bench for tl_source_shrinker.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tl_source_shrinker;

    localparam int SLOT_BITS = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        auto_in_a_ready;
    logic        auto_in_a_valid;
    logic [2:0]  auto_in_a_bits_opcode;
    logic [2:0]  auto_in_a_bits_param;
    logic [1:0]  auto_in_a_bits_size;
    logic [9:0]  auto_in_a_bits_source;
    logic [32:0] auto_in_a_bits_address;
    logic [7:0]  auto_in_a_bits_mask;
    logic [63:0] auto_in_a_bits_data;
    logic        auto_in_a_bits_corrupt;
    logic        auto_in_d_ready;
    logic        auto_in_d_valid;
    logic [2:0]  auto_in_d_bits_opcode;
    logic [1:0]  auto_in_d_bits_param;
    logic [1:0]  auto_in_d_bits_size;
    logic [9:0]  auto_in_d_bits_source;
    logic        auto_in_d_bits_sink;
    logic        auto_in_d_bits_denied;
    logic [63:0] auto_in_d_bits_data;
    logic        auto_in_d_bits_corrupt;
    logic        auto_out_a_ready;
    logic        auto_out_a_valid;
    logic [2:0]  auto_out_a_bits_opcode;
    logic [2:0]  auto_out_a_bits_param;
    logic [1:0]  auto_out_a_bits_size;
    logic [SLOT_BITS-1:0] auto_out_a_bits_source;
    logic [32:0] auto_out_a_bits_address;
    logic [7:0]  auto_out_a_bits_mask;
    logic [63:0] auto_out_a_bits_data;
    logic        auto_out_a_bits_corrupt;
    logic        auto_out_d_ready;
    logic        auto_out_d_valid;
    logic [2:0]  auto_out_d_bits_opcode;
    logic [1:0]  auto_out_d_bits_size;
    logic [SLOT_BITS-1:0] auto_out_d_bits_source;
    logic [63:0] auto_out_d_bits_data;
    logic [SLOT_BITS:0]   inflight;
    logic        protocol_error;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    tl_source_shrinker #(.SLOT_BITS(SLOT_BITS)) dut (
        .clock                   (clock),
        .reset                   (reset),
        .auto_in_a_ready         (auto_in_a_ready),
        .auto_in_a_valid         (auto_in_a_valid),
        .auto_in_a_bits_opcode   (auto_in_a_bits_opcode),
        .auto_in_a_bits_param    (auto_in_a_bits_param),
        .auto_in_a_bits_size     (auto_in_a_bits_size),
        .auto_in_a_bits_source   (auto_in_a_bits_source),
        .auto_in_a_bits_address  (auto_in_a_bits_address),
        .auto_in_a_bits_mask     (auto_in_a_bits_mask),
        .auto_in_a_bits_data     (auto_in_a_bits_data),
        .auto_in_a_bits_corrupt  (auto_in_a_bits_corrupt),
        .auto_in_d_ready         (auto_in_d_ready),
        .auto_in_d_valid         (auto_in_d_valid),
        .auto_in_d_bits_opcode   (auto_in_d_bits_opcode),
        .auto_in_d_bits_param    (auto_in_d_bits_param),
        .auto_in_d_bits_size     (auto_in_d_bits_size),
        .auto_in_d_bits_source   (auto_in_d_bits_source),
        .auto_in_d_bits_sink     (auto_in_d_bits_sink),
        .auto_in_d_bits_denied   (auto_in_d_bits_denied),
        .auto_in_d_bits_data     (auto_in_d_bits_data),
        .auto_in_d_bits_corrupt  (auto_in_d_bits_corrupt),
        .auto_out_a_ready        (auto_out_a_ready),
        .auto_out_a_valid        (auto_out_a_valid),
        .auto_out_a_bits_opcode  (auto_out_a_bits_opcode),
        .auto_out_a_bits_param   (auto_out_a_bits_param),
        .auto_out_a_bits_size    (auto_out_a_bits_size),
        .auto_out_a_bits_source  (auto_out_a_bits_source),
        .auto_out_a_bits_address (auto_out_a_bits_address),
        .auto_out_a_bits_mask    (auto_out_a_bits_mask),
        .auto_out_a_bits_data    (auto_out_a_bits_data),
        .auto_out_a_bits_corrupt (auto_out_a_bits_corrupt),
        .auto_out_d_ready        (auto_out_d_ready),
        .auto_out_d_valid        (auto_out_d_valid),
        .auto_out_d_bits_opcode  (auto_out_d_bits_opcode),
        .auto_out_d_bits_size    (auto_out_d_bits_size),
        .auto_out_d_bits_source  (auto_out_d_bits_source),
        .auto_out_d_bits_data    (auto_out_d_bits_data),
        .inflight                (inflight),
        .protocol_error          (protocol_error)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge and let outputs settle.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [9:0] src);
        auto_in_a_valid       = v;
        auto_in_a_bits_source = src;
    endtask

    task automatic drive_d(input logic v, input logic [SLOT_BITS-1:0] slot);
        auto_out_d_valid       = v;
        auto_out_d_bits_source = slot;
    endtask

    initial begin
        reset                  = 1'b1;
        auto_in_a_valid        = 1'b0;
        auto_in_a_bits_opcode  = 3'd4;
        auto_in_a_bits_param   = 3'd0;
        auto_in_a_bits_size    = 2'd3;
        auto_in_a_bits_source  = 10'h0;
        auto_in_a_bits_address = 33'h1_2345_6780;
        auto_in_a_bits_mask    = 8'hFF;
        auto_in_a_bits_data    = 64'hDEAD_BEEF_0123_4567;
        auto_in_a_bits_corrupt = 1'b0;
        auto_in_d_ready        = 1'b1;
        auto_out_a_ready       = 1'b1;
        auto_out_d_valid       = 1'b0;
        auto_out_d_bits_opcode = 3'd1;
        auto_out_d_bits_size   = 2'd3;
        auto_out_d_bits_source = '0;
        auto_out_d_bits_data   = 64'hCAFE_F00D_8765_4321;

        // Reset state
        #12;
        check("rst_inflight", 64'(inflight), 64'd0);
        check("rst_perr", 64'(protocol_error), 64'd0);
        check("rst_out_a_src", 64'(auto_out_a_bits_source), 64'd0);
        check("rst_in_a_ready", 64'(auto_in_a_ready), 64'd1);
        reset = 1'b0;
        tick();

        // Single request / response
        drive_a(1'b1, 10'h2A5);
        #1;
        check("single_out_a_valid", 64'(auto_out_a_valid), 64'd1);
        check("single_out_a_src", 64'(auto_out_a_bits_source), 64'd0);
        check("single_addr", 64'(auto_out_a_bits_address), 64'h1_2345_6780);
        check("single_a_data", auto_out_a_bits_data, 64'hDEAD_BEEF_0123_4567);
        tick();
        drive_a(1'b0, 10'h0);
        check("single_inflight1", 64'(inflight), 64'd1);
        drive_d(1'b1, 2'd0);
        #1;
        check("single_in_d_valid", 64'(auto_in_d_valid), 64'd1);
        check("single_in_d_src", 64'(auto_in_d_bits_source), 64'h2A5);
        check("single_d_data", auto_in_d_bits_data, 64'hCAFE_F00D_8765_4321);
        check("single_d_param", 64'(auto_in_d_bits_param), 64'd0);
        tick();
        drive_d(1'b0, 2'd0);
        check("single_inflight0", 64'(inflight), 64'd0);

        // Fill all four slots
        for (int i = 0; i < 4; i++) begin
            drive_a(1'b1, 10'(i + 1));
            #1;
            check($sformatf("fill_slot%0d", i), 64'(auto_out_a_bits_source), 64'(i));
            tick();
        end
        drive_a(1'b1, 10'h005);
        #1;
        check("full_in_a_ready", 64'(auto_in_a_ready), 64'd0);
        check("full_out_a_valid", 64'(auto_out_a_valid), 64'd0);
        check("full_inflight", 64'(inflight), 64'd4);

        // Out-of-order return on slot 2 while full
        drive_d(1'b1, 2'd2);
        #1;
        check("ooo_in_d_src", 64'(auto_in_d_bits_source), 64'h003);
        check("ooo_same_cycle_blocked", 64'(auto_in_a_ready), 64'd0);
        tick();
        drive_d(1'b0, 2'd0);
        check("ooo_out_a_valid", 64'(auto_out_a_valid), 64'd1);
        check("ooo_realloc_slot", 64'(auto_out_a_bits_source), 64'd2);
        check("ooo_inflight3", 64'(inflight), 64'd3);
        tick();
        drive_a(1'b0, 10'h0);
        check("ooo_inflight4", 64'(inflight), 64'd4);
        // table: 0:001 1:002 2:005 3:004

        // Free slot 3 so slots 0-2 are busy
        drive_d(1'b1, 2'd3);
        #1;
        check("free3_in_d_src", 64'(auto_in_d_bits_source), 64'h004);
        tick();
        check("free3_inflight", 64'(inflight), 64'd3);

        // Simultaneous A fire and D fire on slot 1
        drive_a(1'b1, 10'h100);
        drive_d(1'b1, 2'd1);
        #1;
        check("simul_out_a_src", 64'(auto_out_a_bits_source), 64'd3);
        check("simul_in_d_src", 64'(auto_in_d_bits_source), 64'h002);
        tick();
        drive_d(1'b0, 2'd0);
        check("simul_inflight", 64'(inflight), 64'd3);
        drive_a(1'b1, 10'h101);
        #1;
        check("simul_next_slot", 64'(auto_out_a_bits_source), 64'd1);
        tick();
        drive_a(1'b0, 10'h0);
        check("simul_inflight4", 64'(inflight), 64'd4);
        // table: 0:001 1:101 2:005 3:100

        // Free slot 0
        drive_d(1'b1, 2'd0);
        #1;
        check("free0_in_d_src", 64'(auto_in_d_bits_source), 64'h001);
        tick();
        drive_d(1'b0, 2'd0);

        // A backpressure for 5 cycles
        auto_out_a_ready = 1'b0;
        drive_a(1'b1, 10'h222);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_a_in_ready", 64'(auto_in_a_ready), 64'd0);
            check("bp_a_out_valid", 64'(auto_out_a_valid), 64'd1);
            tick();
        end
        check("bp_a_inflight", 64'(inflight), 64'd3);
        drive_a(1'b0, 10'h0);

        // D backpressure for 5 cycles
        auto_in_d_ready = 1'b0;
        drive_d(1'b1, 2'd2);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_d_out_ready", 64'(auto_out_d_ready), 64'd0);
            tick();
        end
        check("bp_d_inflight", 64'(inflight), 64'd3);

        // Release both: A takes slot 0, D frees slot 2
        auto_in_d_ready  = 1'b1;
        auto_out_a_ready = 1'b1;
        drive_a(1'b1, 10'h222);
        #1;
        check("rel_out_a_src", 64'(auto_out_a_bits_source), 64'd0);
        check("rel_in_d_src", 64'(auto_in_d_bits_source), 64'h005);
        tick();
        drive_a(1'b0, 10'h0);
        drive_d(1'b0, 2'd0);
        check("rel_inflight", 64'(inflight), 64'd3);

        // D on unoccupied slot 2: stale ID forwarded, sticky error
        drive_d(1'b1, 2'd2);
        #1;
        check("err_stale_src", 64'(auto_in_d_bits_source), 64'h005);
        check("err_pre_perr", 64'(protocol_error), 64'd0);
        tick();
        drive_d(1'b0, 2'd0);
        check("err_perr_set", 64'(protocol_error), 64'd1);
        check("err_inflight", 64'(inflight), 64'd3);
        tick();
        tick();
        check("err_perr_sticky", 64'(protocol_error), 64'd1);

        // Asynchronous reset mid-burst, observed before the next edge
        drive_a(1'b1, 10'h333);
        #2;
        reset = 1'b1;
        #1;
        check("arst_inflight", 64'(inflight), 64'd0);
        check("arst_perr", 64'(protocol_error), 64'd0);
        check("arst_out_a_src", 64'(auto_out_a_bits_source), 64'd0);
        #1;
        reset = 1'b0;
        drive_a(1'b0, 10'h0);
        drive_d(1'b1, 2'd0);
        #1;
        check("post_rst_d_src", 64'(auto_in_d_bits_source), 64'h000);
        tick();
        drive_d(1'b0, 2'd0);
        check("post_rst_perr", 64'(protocol_error), 64'd1);
        check("post_rst_inflight", 64'(inflight), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
